// File: rtl/control_div.sv
// Restoring shift-subtract divider (FSM + datapath); optional signed mode via `define DIV_SIGNED_EN.
// Latency: done rises 2*WIDTH+k cycles after init is sampled (k = quotient ones, +1 signed); 1 cycle on /0.
// Backpressure: none; init is only sampled in START, done holds DONE_HOLD cycles for the bus to poll.
module control_div #(
    parameter int WIDTH     = 16,
    parameter int DONE_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

`ifdef DIV_SIGNED_EN
    typedef enum logic [2:0] {START, SHIFT, CHECK, SUB, FIX, END} state_t;
`else
    typedef enum logic [2:0] {START, SHIFT, CHECK, SUB, END} state_t;
`endif

    state_t           state;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic [HW-1:0]    hold;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   r_sub;
    logic [WIDTH-1:0] q_set;
    logic             last_iter;
`ifdef DIV_SIGNED_EN
    logic             sgn_n;
    logic             sgn_d;
`endif

    // Operand magnitudes fed to the unsigned core, plus the subtract-step results
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
`ifdef DIV_SIGNED_EN
        if (dividend[WIDTH-1]) dvd_mag = -dividend;
        if (divisor[WIDTH-1])  dvs_mag = -divisor;
`endif
        r_sub     = r - {1'b0, d};
        q_set     = {q[WIDTH-1:1], 1'b1};
        last_iter = (cnt == CW'(WIDTH));
    end

    // Control FSM and datapath; every output is registered here
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= START;
            r         <= '0;
            d         <= '0;
            q         <= '0;
            cnt       <= '0;
            hold      <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_SIGNED_EN
            sgn_n     <= 1'b0;
            sgn_d     <= 1'b0;
`endif
        end else begin
            case (state)
                START: begin
                    if (init) begin
                        d        <= dvs_mag;
                        q        <= dvd_mag;
                        r        <= '0;
                        cnt      <= '0;
                        hold     <= '0;
                        div_zero <= 1'b0;
                        busy     <= 1'b1;
`ifdef DIV_SIGNED_EN
                        sgn_n    <= dividend[WIDTH-1];
                        sgn_d    <= divisor[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            // done is raised on the first END cycle, giving 1-cycle latency
                            div_zero  <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                            state     <= END;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r     <= {r[WIDTH-1:0], q[WIDTH-1]};
                    q     <= {q[WIDTH-2:0], 1'b0};
                    cnt   <= cnt + CW'(1);
                    state <= CHECK;
                end
                CHECK: begin
                    if (r >= {1'b0, d}) begin
                        state <= SUB;
                    end else if (last_iter) begin
`ifdef DIV_SIGNED_EN
                        state     <= FIX;
`else
                        quotient  <= q;
                        remainder <= r[WIDTH-1:0];
                        done      <= 1'b1;
                        state     <= END;
`endif
                    end else begin
                        state <= SHIFT;
                    end
                end
                SUB: begin
                    r <= r_sub;
                    q <= q_set;
                    if (last_iter) begin
`ifdef DIV_SIGNED_EN
                        state     <= FIX;
`else
                        quotient  <= q_set;
                        remainder <= r_sub[WIDTH-1:0];
                        done      <= 1'b1;
                        state     <= END;
`endif
                    end else begin
                        state <= SHIFT;
                    end
                end
`ifdef DIV_SIGNED_EN
                FIX: begin
                    // Quotient negative when signs differ; remainder follows the dividend
                    quotient  <= (sgn_n ^ sgn_d) ? -q : q;
                    remainder <= sgn_n ? -r[WIDTH-1:0] : r[WIDTH-1:0];
                    done      <= 1'b1;
                    state     <= END;
                end
`endif
                END: begin
                    if (!done) begin
                        done <= 1'b1;
                    end else if (hold == HW'(DONE_HOLD - 1)) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        hold  <= '0;
                        state <= START;
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                default: state <= START;
            endcase
        end
    end

endmodule

// File: doc/control_div.md
Name: control_div

Overview:
- Sequential restoring shift-subtract divider: control FSM plus datapath in one block.
- Inverse companion to the shift-add multiplier core; exposes the same `init`/`done` handshake to the femtoRV peripheral wrapper.
- Computes `quotient` and `remainder` of `dividend`/`divisor` one bit per iteration.
- Holds `done` long enough for the bus side to poll it before returning to idle.

Parameters:
- WIDTH, 16: operand, quotient and remainder width in bits.
- DONE_HOLD, 15: number of cycles `done` stays high in END before returning to START.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset.
- init  input  1  start request; level-sampled in START only.
- dividend  input  WIDTH  numerator; captured when `init` is accepted.
- divisor  input  WIDTH  denominator; captured when `init` is accepted.
- quotient  output  WIDTH  result; valid while `done`=1, held until the next accepted `init`.
- remainder  output  WIDTH  result; same validity as `quotient`.
- done  output  1  result valid, high for DONE_HOLD cycles.
- busy  output  1  high in every state except START.
- div_zero  output  1  divisor was zero; valid with `done`.

Behaviour:
- Reset (`rst`=0 at a clock edge):
  - state = START; `done`=0, `busy`=0, `div_zero`=0; `quotient`=0, `remainder`=0.
  - Internal R, D, Q and counters are cleared.
  - Reset takes effect from any state, including mid-division; the partial result is discarded.
- Datapath registers:
  - R: WIDTH+1 bits, partial remainder.
  - D: WIDTH bits, divisor.
  - Q: WIDTH bits, dividend shifting out / quotient shifting in.
  - cnt: iteration counter, 0..WIDTH.
- States: START, SHIFT, CHECK, SUB, END (plus FIX when the optional feature is enabled).
- START:
  - `busy`=0.
  - If `init`=1: capture D=`divisor`, Q=`dividend`, R=0, cnt=0, `div_zero`=0.
  - Then, if `divisor`==0: set `div_zero`=1, `quotient`=all ones, `remainder`=`dividend`, go to END.
  - Otherwise go to SHIFT.
  - If `init`=0: stay in START.
- SHIFT: {R,Q} <= {R,Q}<<1 (Q MSB enters R LSB, Q LSB=0); cnt <= cnt+1; go to CHECK.
- CHECK:
  - If R >= D (unsigned, WIDTH+1-bit compare), go to SUB.
  - Else if cnt==WIDTH, go to END.
  - Else go to SHIFT.
- SUB: R <= R-D; Q[0] <= 1; if cnt==WIDTH go to END, else go to SHIFT.
- On entry to END from CHECK or SUB: `quotient`=Q, `remainder`=R[WIDTH-1:0].
- END:
  - `done`=1; a hold counter increments each cycle.
  - After DONE_HOLD cycles in END, go to START and drop `done`.
  - `quotient` and `remainder` stay stable.
- Latency:
  - Let k be the number of 1 bits in the quotient.
  - Normal case: `done` first high 2*WIDTH+k cycles after the edge that sampled `init`.
  - Divide-by-zero: `done` first high 1 cycle after that edge.
- Handshake and boundary rules:
  - `init` is ignored in every state other than START.
  - If `init` is still high when FSM re-enters START, a new operation starts on that edge with freshly sampled operands.
  - Operands may change after acceptance without affecting the result.
  - `dividend` < `divisor` gives `quotient`=0, `remainder`=`dividend`.
  - `dividend`=0 with nonzero `divisor` gives 0/0 outputs, normal latency.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement. Absolute values are captured in START; the operand signs are stored.
  - The unsigned core runs unchanged.
  - END is reached via an extra FIX state, adding 1 cycle of latency.
  - FIX negates `quotient` if the operand signs differ; `remainder` takes the sign of `dividend`.
  - Most-negative divided by -1: quotient wraps to the most-negative value, remainder 0.
  - Divide-by-zero: `quotient`=all ones (-1), `remainder`=`dividend`; FIX is skipped.
- Undefined: purely unsigned; no FIX state.

Test Plan:
- Basic division, WIDTH=16: `dividend`=100, `divisor`=7, `init` pulse -> `quotient`=14, `remainder`=2, `div_zero`=0. `done` rises 35 cycles after `init` is sampled, stays high exactly 15 cycles, then `busy`=0.
- Maximum quotient bits: `dividend`=0xFFFF, `divisor`=1 -> `quotient`=0xFFFF, `remainder`=0, `done` at 48 cycles.
- Dividend smaller than divisor: `dividend`=3, `divisor`=10 -> `quotient`=0, `remainder`=3, `done` at 32 cycles.
- Divide-by-zero: `dividend`=5, `divisor`=0 -> `div_zero`=1, `quotient`=0xFFFF, `remainder`=5, `done` 1 cycle after `init`.
- Reset and ignored `init`:
  - Start 100/7, pulse `init` again with 50/5 at cycle 10 -> still 14 r 2.
  - Repeat, assert `rst`=0 at cycle 20 -> next cycle `busy`=0, `done`=0, `quotient`=0, `remainder`=0.
  - A following 50/5 -> 10 r 0.
- DIV_SIGNED_EN: -100/7 -> `quotient`=0xFFF2, `remainder`=0xFFFE, `done` at 36 cycles. 0x8000/0xFFFF -> `quotient`=0x8000, `remainder`=0.
